// File: rtl/adrv9009_rsp_pkg.sv
// Shared types and constants for the RFIR configuration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adrv9009_rsp_pkg;

    localparam int COEFF_W = 16;
    localparam int ADDR_W  = 7;
    localparam int CTRL_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_APPLY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    // Host request captured on an accepted start.
    typedef struct packed {
        logic              en;
        logic              load;
        logic [CTRL_W-1:0] mode;
        logic [CTRL_W-1:0] gain;
        logic [CTRL_W-1:0] deci;
    } cfg_t;

    // Tap count for a mode code: 24 * (mode + 1).
    function automatic logic [ADDR_W-1:0] ntaps(input logic [CTRL_W-1:0] mode);
        logic [ADDR_W-1:0] n;
        case (mode)
            2'd0:    n = 7'd24;
            2'd1:    n = 7'd48;
            2'd2:    n = 7'd72;
            default: n = 7'd96;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/adrv9009_cycle_timer.sv
// Loadable down-counter with a zero flag; load has priority over decrement,
// and the count saturates at zero. Latency: zero_o is registered, 1 cycle after load.
// Backpressure: none; dec_i simply pauses the count when low.
// Ports: clk_m/reset (async, active-high), load_i/load_val_i, dec_i, zero_o.
module adrv9009_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk_m,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_m or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adrv9009_rfir_cfg_ctrl.sv
// RFIR reconfiguration sequencer: disable, drain, load coefficient RAM, settle, apply.
// Latency: all outputs registered; a RAM write lands 1 cycle after its handshake.
// Backpressure: s_ready is high only while taps remain to be loaded in LOAD.
// Ports: host request (cfg_*, abort), coefficient stream (s_valid/s_ready/s_coeff),
// RFIR controls (en/mode/gain/deci_rfir), RAM write port (wr_en/addr_in/coeff_in),
// status (busy, done, err_timeout, err_abort).
module adrv9009_rfir_cfg_ctrl
    import adrv9009_rsp_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOAD_TIMEOUT  = 1024
) (
    input  logic                      clk_m,
    input  logic                      reset,
    input  logic                      cfg_start,
    input  logic                      cfg_load,
    input  logic                      cfg_en,
    input  logic [CTRL_W-1:0]         cfg_mode,
    input  logic [CTRL_W-1:0]         cfg_gain,
    input  logic [CTRL_W-1:0]         cfg_deci,
    input  logic                      abort,
    input  logic                      s_valid,
    input  logic signed [COEFF_W-1:0] s_coeff,
    output logic                      s_ready,
    output logic                      en_rfir,
    output logic [CTRL_W-1:0]         mode_rfir,
    output logic [CTRL_W-1:0]         gain_rfir,
    output logic [CTRL_W-1:0]         deci_rfir,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         addr_in,
    output logic signed [COEFF_W-1:0] coeff_in,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout,
    output logic                      err_abort
);

    localparam int PH_W = $clog2(DRAIN_CYCLES + SETTLE_CYCLES + 1);
    localparam int TO_W = $clog2(LOAD_TIMEOUT + 1);

    // Timer is loaded with (cycles - 1) on the edge that enters the state.
    // After a load, SETTLE also covers the cycle in which the last write lands,
    // so it is loaded one higher to count SETTLE_CYCLES after that write.
    localparam logic [PH_W-1:0] PH_DRAIN       = PH_W'(DRAIN_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_SETTLE_CFG  = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_SETTLE_LOAD = PH_W'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0] TO_RELOAD      = TO_W'(LOAD_TIMEOUT - 1);

    state_e state_q, state_d;

    cfg_t                      shadow_q, shadow_d;
    logic [ADDR_W-1:0]         tap_q, tap_d;
    logic                      en_q, en_d;
    logic [CTRL_W-1:0]         mode_q, mode_d, gain_q, gain_d, deci_q, deci_d;
    logic                      wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic signed [COEFF_W-1:0] coeff_q, coeff_d;
    logic                      s_ready_q, s_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_to_q, err_to_d;
    logic                      err_ab_q, err_ab_d;

    logic              ph_load, ph_zero;
    logic [PH_W-1:0]   ph_val;
    logic              to_load, to_dec, to_zero;
    logic              hs, last_tap;

    // s_ready_q is high only in LOAD, so hs implies LOAD.
    assign hs       = s_valid && s_ready_q;
    assign last_tap = (tap_q == (ntaps(shadow_q.mode) - 7'd1));
    assign to_dec   = (state_q == ST_LOAD) && !hs;

    adrv9009_cycle_timer #(.W(PH_W)) u_phase_tmr (
        .clk_m      (clk_m),
        .reset      (reset),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .dec_i      (1'b1),
        .zero_o     (ph_zero)
    );

    adrv9009_cycle_timer #(.W(TO_W)) u_idle_tmr (
        .clk_m      (clk_m),
        .reset      (reset),
        .load_i     (to_load),
        .load_val_i (TO_RELOAD),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );

    // State register
    always_ff @(posedge clk_m or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and timer control
    always_comb begin
        state_d = state_q;
        ph_load = 1'b0;
        ph_val  = '0;
        to_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_DRAIN;
                    ph_load = 1'b1;
                    ph_val  = PH_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_FAULT;
                end else if (ph_zero) begin
                    if (shadow_q.load) begin
                        state_d = ST_LOAD;
                        to_load = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        ph_load = 1'b1;
                        ph_val  = PH_SETTLE_CFG;
                    end
                end
            end
            ST_LOAD: begin
                // Abort outranks both a handshake and a timeout in the same cycle.
                if (abort) begin
                    state_d = ST_FAULT;
                end else if (hs) begin
                    to_load = 1'b1;
                    if (last_tap) begin
                        state_d = ST_SETTLE;
                        ph_load = 1'b1;
                        ph_val  = PH_SETTLE_LOAD;
                    end
                end else if (to_zero) begin
                    state_d = ST_FAULT;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_FAULT;
                end else if (ph_zero) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-state
    always_comb begin
        shadow_d  = shadow_q;
        tap_d     = tap_q;
        en_d      = en_q;
        mode_d    = mode_q;
        gain_d    = gain_q;
        deci_d    = deci_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        coeff_d   = coeff_q;
        done_d    = 1'b0;
        err_to_d  = err_to_q;
        err_ab_d  = err_ab_q;
        s_ready_d = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    shadow_d = '{en: cfg_en, load: cfg_load, mode: cfg_mode,
                                 gain: cfg_gain, deci: cfg_deci};
                    tap_d    = '0;
                    en_d     = 1'b0;
                    err_to_d = 1'b0;
                    err_ab_d = 1'b0;
                end
            end
            ST_DRAIN, ST_SETTLE: begin
                if (abort) begin
                    err_ab_d = 1'b1;
                    en_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    err_ab_d = 1'b1;
                    en_d     = 1'b0;
                end else if (hs) begin
                    wr_en_d = 1'b1;
                    addr_d  = tap_q;
                    coeff_d = s_coeff;
                    tap_d   = tap_q + 7'd1;
                end else if (to_zero) begin
                    err_to_d = 1'b1;
                    en_d     = 1'b0;
                end
            end
            ST_APPLY: begin
                en_d   = shadow_q.en;
                mode_d = shadow_q.mode;
                gain_d = shadow_q.gain;
                deci_d = shadow_q.deci;
                done_d = 1'b1;
            end
            ST_FAULT: begin
                en_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_m or posedge reset) begin
        if (reset) begin
            shadow_q  <= '0;
            tap_q     <= '0;
            en_q      <= 1'b0;
            mode_q    <= '0;
            gain_q    <= '0;
            deci_q    <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            coeff_q   <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_to_q  <= 1'b0;
            err_ab_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            tap_q     <= tap_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            gain_q    <= gain_d;
            deci_q    <= deci_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            coeff_q   <= coeff_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_to_q  <= err_to_d;
            err_ab_q  <= err_ab_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign en_rfir     = en_q;
    assign mode_rfir   = mode_q;
    assign gain_rfir   = gain_q;
    assign deci_rfir   = deci_q;
    assign wr_en       = wr_en_q;
    assign addr_in     = addr_q;
    assign coeff_in    = coeff_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_to_q;
    assign err_abort   = err_ab_q;

endmodule

// File: tb/tb_adrv9009_rfir_cfg_ctrl.sv
// Bench for adrv9009_rfir_cfg_ctrl: table of directed sequences plus reset cases.
// Cycle k = k-th falling edge after the edge that samples cfg_start.
// Expected cycles are hand-derived for DRAIN=32, SETTLE=4, LOAD_TIMEOUT=1024.
module tb_adrv9009_rfir_cfg_ctrl;

    logic               clk_m = 1'b0;
    logic               reset;
    logic               cfg_start, cfg_load, cfg_en, abort, s_valid;
    logic [1:0]         cfg_mode, cfg_gain, cfg_deci;
    logic signed [15:0] s_coeff;
    logic               s_ready, en_rfir, wr_en, busy, done, err_timeout, err_abort;
    logic [1:0]         mode_rfir, gain_rfir, deci_rfir;
    logic [6:0]         addr_in;
    logic signed [15:0] coeff_in;
    logic [35:0]        outs;

    int n_checks = 0;
    int n_fail   = 0;

    adrv9009_rfir_cfg_ctrl dut (
        .clk_m       (clk_m),
        .reset       (reset),
        .cfg_start   (cfg_start),
        .cfg_load    (cfg_load),
        .cfg_en      (cfg_en),
        .cfg_mode    (cfg_mode),
        .cfg_gain    (cfg_gain),
        .cfg_deci    (cfg_deci),
        .abort       (abort),
        .s_valid     (s_valid),
        .s_coeff     (s_coeff),
        .s_ready     (s_ready),
        .en_rfir     (en_rfir),
        .mode_rfir   (mode_rfir),
        .gain_rfir   (gain_rfir),
        .deci_rfir   (deci_rfir),
        .wr_en       (wr_en),
        .addr_in     (addr_in),
        .coeff_in    (coeff_in),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_abort   (err_abort)
    );

    assign outs = {en_rfir, mode_rfir, gain_rfir, deci_rfir, wr_en, addr_in, coeff_in,
                   s_ready, busy, done, err_timeout, err_abort};

    always #5 clk_m = ~clk_m;

    typedef struct {
        bit       load;
        bit [1:0] mode, gain, deci;
        bit       en;
        int       n_send;      // coefficients offered (may exceed tap count)
        bit       thr;         // s_valid only on even cycles
        int       abort_hs;    // handshake index that carries abort, -1 = none
        int       drop_at;     // cycle of a start pulse while busy, -1 = none
        int       e_done;      // cycle done is seen, -1 = never
        int       e_ndone;
        int       e_nwr;
        int       e_busy_low;
        bit [1:0] e_mode, e_gain, e_deci;
        bit       e_en, e_to, e_ab;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int sent = 0, nwr = 0, ndone = 0, done_cyc = -1, busy_low = -1;
        int wr_err = 0, seq_err = 0;
        bit exp_wr = 1'b0, hs;
        logic snap_en = 1'bx, snap_busy = 1'bx, snap_to = 1'bx, snap_ab = 1'bx;
        string p = $sformatf("v%0d_", idx);

        @(negedge clk_m);
        cfg_load  = v.load;
        cfg_mode  = v.mode;
        cfg_gain  = v.gain;
        cfg_deci  = v.deci;
        cfg_en    = v.en;
        cfg_start = 1'b1;
        for (int k = 1; k <= 1500; k++) begin
            @(negedge clk_m);
            cfg_start = 1'b0;
            if (k == v.drop_at) begin
                cfg_start = 1'b1;
                cfg_load  = ~v.load;
                cfg_mode  = ~v.mode;
                cfg_gain  = ~v.gain;
                cfg_deci  = ~v.deci;
                cfg_en    = ~v.en;
            end
            if (wr_en !== exp_wr) wr_err++;
            if (wr_en === 1'b1) begin
                if (addr_in !== 7'(nwr) || coeff_in !== 16'(100 + nwr)) seq_err++;
                nwr++;
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = k;
            end
            if (k == 1) begin
                snap_en   = en_rfir;
                snap_busy = busy;
                snap_to   = err_timeout;
                snap_ab   = err_abort;
            end
            if (busy === 1'b0) begin
                busy_low = k;
                break;
            end
            s_valid = (sent < v.n_send) && (!v.thr || (k % 2) == 0);
            s_coeff = 16'(100 + sent);
            hs      = s_valid && (s_ready === 1'b1);
            abort   = (v.abort_hs >= 0) && hs && (sent == v.abort_hs);
            exp_wr  = hs && !abort;
            if (hs) sent++;
        end
        s_valid = 1'b0;
        abort   = 1'b0;

        check({p, "done_cycle"},   done_cyc,    v.e_done);
        check({p, "done_count"},   ndone,       v.e_ndone);
        check({p, "write_count"},  nwr,         v.e_nwr);
        check({p, "addr_coeff"},   seq_err,     0);
        check({p, "wr_latency"},   wr_err,      0);
        check({p, "busy_low_cyc"}, busy_low,    v.e_busy_low);
        check({p, "mode_rfir"},    mode_rfir,   v.e_mode);
        check({p, "gain_rfir"},    gain_rfir,   v.e_gain);
        check({p, "deci_rfir"},    deci_rfir,   v.e_deci);
        check({p, "en_rfir"},      en_rfir,     v.e_en);
        check({p, "err_timeout"},  err_timeout, v.e_to);
        check({p, "err_abort"},    err_abort,   v.e_ab);
        check({p, "c1_en_low"},    snap_en,     0);
        check({p, "c1_busy"},      snap_busy,   1);
        check({p, "c1_err_clr"},   {snap_to, snap_ab}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //            load  mode  gain  deci  en   send thr abort drop  done nd nwr blow  mode  gain  deci  en    to    ab
        tbl[0] = '{1'b0, 2'd2, 2'd2, 2'd1, 1'b1,  0, 1'b0, -1, -1,   38, 1,  0,   38, 2'd2, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 2'd1, 2'd2, 1'b1, 50, 1'b0, -1, -1,   87, 1, 48,   87, 2'd1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'd3, 2'd3, 2'd3, 1'b0, 96, 1'b1, -1, -1,  231, 1, 96,  231, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 2'd1, 2'd0, 1'b1,  0, 1'b0, -1, 10,   38, 1,  0,   38, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2'd1, 2'd2, 2'd2, 1'b1, 10, 1'b0, -1, -1,   -1, 0, 10, 1068, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 2'd2, 2'd0, 2'd1, 1'b1, 72, 1'b0,  4, -1,   -1, 0,  4,   39, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 24, 1'b0, -1, -1,   63, 1, 24,   63, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 2'd3, 2'd2, 2'd1, 1'b1,  0, 1'b0, -1, -1,   38, 1,  0,   38, 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0};

        cfg_start = 1'b0;
        cfg_load  = 1'b0;
        cfg_en    = 1'b0;
        cfg_mode  = 2'd0;
        cfg_gain  = 2'd0;
        cfg_deci  = 2'd0;
        abort     = 1'b0;
        s_valid   = 1'b0;
        s_coeff   = 16'sd0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        #1 check("reset_outputs", outs, 0);
        repeat (3) @(negedge clk_m);
        reset = 1'b0;
        repeat (2) @(negedge clk_m);
        check("idle_after_reset", outs, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], i);
            repeat (2) @(negedge clk_m);
        end

        // Reset in the middle of a load: everything clears before the next edge.
        @(negedge clk_m);
        cfg_load  = 1'b1;
        cfg_mode  = 2'd1;
        cfg_gain  = 2'd0;
        cfg_deci  = 2'd0;
        cfg_en    = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk_m);
        cfg_start = 1'b0;
        s_valid   = 1'b1;
        s_coeff   = 16'sh1234;
        repeat (38) @(negedge clk_m);
        check("pre_reset_busy_wr_rdy", {busy, wr_en, s_ready}, 3'b111);
        check("pre_reset_cfg_held", {mode_rfir, gain_rfir, deci_rfir}, 6'b11_10_01);
        #2 reset = 1'b1;
        #1 check("reset_async_outputs", outs, 0);
        @(negedge clk_m);
        reset   = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk_m);

        // Full reconfiguration from the post-reset state.
        run_vec(tbl[0], 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adrv9009_rfir_cfg_ctrl.md
Name: adrv9009_rfir_cfg_ctrl

Overview:
- Configuration sequencer for the RFIR stage and its coefficient RAM.
- Accepts a host reconfiguration request and an optional coefficient stream. Disables the RFIR, flushes it, writes the coefficients into the coefficient RAM write port, then applies the new mode/gain/decimation and re-enables.
- Sits between the host/register interface and the `en_rfir`/`mode_rfir`/`gain_rfir`/`deci_rfir` and `wr_en`/`addr_in`/`coeff_in` inputs of the receive path.

Parameters:
- `DRAIN_CYCLES`, 32: cycles `en_rfir` is held low before the first RAM write (pipeline flush).
- `SETTLE_CYCLES`, 4: cycles after the last write before new config is applied.
- `LOAD_TIMEOUT`, 1024: maximum idle cycles waiting for `s_valid` in LOAD.

Ports:
- `clk_m` in 1: single clock. RAM write clock `clk_r` is tied to `clk_m` at integration.
- `reset` in 1: asynchronous, active-high.
- `cfg_start` in 1: single-cycle request; ignored unless `busy`=0.
- `cfg_load` in 1: 1 = load coefficients, 0 = reconfigure only.
- `cfg_en` in 1: `en_rfir` value applied at APPLY.
- `cfg_mode` in 2: tap mode. 0/1/2/3 = 24/48/72/96 taps.
- `cfg_gain` in 2: gain code.
- `cfg_deci` in 2: decimation code.
- `abort` in 1: abandon the sequence.
- `s_valid` in 1: coefficient valid.
- `s_coeff` in 16 (signed): coefficient.
- `s_ready` out 1: coefficient accepted when `s_valid` and `s_ready` are both high.
- `en_rfir` out 1; `mode_rfir` out 2; `gain_rfir` out 2; `deci_rfir` out 2: RFIR controls.
- `wr_en` out 1; `addr_in` out 7; `coeff_in` out 16 (signed): RAM write port.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on successful APPLY.
- `err_timeout` out 1: sticky; cleared by the next accepted `cfg_start`.
- `err_abort` out 1: sticky; cleared by the next accepted `cfg_start`.

Behaviour:
- All outputs are registered.
- Reset values:
  - `en_rfir`=0, `mode`/`gain`/`deci`=0.
  - `wr_en`=0, `addr_in`=0, `coeff_in`=0.
  - `s_ready`=0, `busy`=0, `done`=0, both err flags=0.
  - State = IDLE, counters = 0.
- Reset mid-sequence returns to these values immediately. Partially written RAM contents are undefined.
- States: IDLE, DRAIN, LOAD, SETTLE, APPLY, FAULT.
- IDLE:
  - On `cfg_start`, latch `cfg_*` into shadow registers and clear err flags.
  - `en_rfir`←0 on the next edge; go to DRAIN.
  - `cfg_start` while `busy`=1 is dropped with no effect.
- DRAIN:
  - Count `DRAIN_CYCLES` cycles.
  - Then go to LOAD if `cfg_load`=1, else to SETTLE.
- LOAD:
  - `s_ready`=1. N = 24·(mode+1) taps, from the shadowed mode.
  - Each handshake: next cycle `wr_en`=1, `addr_in`=tap index (0..N-1, ascending), `coeff_in`=`s_coeff`.
  - Write latency is 1 cycle from handshake. `wr_en` is 0 on cycles without a handshake.
  - Handshakes may be back-to-back.
  - On the Nth handshake, `s_ready` drops in the same cycle the Nth handshake is registered, so no N+1th coefficient is accepted. Go to SETTLE.
  - Timeout counter resets on every handshake. If it reaches `LOAD_TIMEOUT`: set `err_timeout`, go to FAULT.
- SETTLE: wait `SETTLE_CYCLES` cycles, counted from the cycle after the last write. Then go to APPLY.
- APPLY (1 cycle):
  - `mode_rfir`/`gain_rfir`/`deci_rfir` ← shadow values; `en_rfir` ← shadow `cfg_en`.
  - `done` pulses; return to IDLE.
  - The config outputs change only here; they are never updated mid-load.
- FAULT:
  - `en_rfir`=0, `s_ready`=0, `busy`=1; the config outputs keep their previous values.
  - Exit to IDLE one cycle later; err flags persist.
- `abort`:
  - In DRAIN, LOAD or SETTLE: set `err_abort`, deassert `s_ready` and `wr_en` next cycle, go to FAULT.
  - Ignored in IDLE and APPLY.
  - `abort` coinciding with a LOAD handshake: that coefficient is not written.
  - `abort` and timeout in the same cycle: `abort` wins; only `err_abort` is set.
- Address width: max address is 95 (< 128); the tap counter is 7 bits and never wraps.

Decomposition:
- Shared package `adrv9009_rsp_pkg`:
  - State enum.
  - Tap-count function `ntaps(mode)`.
  - Widths: coefficient 16, address 7, control 2.
- One natural sub-module, `adrv9009_cycle_timer`: a loadable down-counter with a zero flag, instanced for the DRAIN/SETTLE counts and for the LOAD timeout.

Test Plan:
- Reconfigure only:
  - Stimulus: `cfg_start` with `cfg_load`=0, gain=2, deci=1, en=1; defaults DRAIN=32, SETTLE=4.
  - Response: `en_rfir` low 1 cycle after start; `gain_rfir`=2, `deci_rfir`=1, `en_rfir`=1 and a `done` pulse exactly 38 cycles after `cfg_start`; no `wr_en`.
- Full 48-tap load:
  - Stimulus: mode=1, back-to-back coefficients 100..147.
  - Response: 48 `wr_en` pulses at `addr_in` 0..47 with `coeff_in` 100..147, each 1 cycle after its handshake; `s_ready` low after the 48th; `mode_rfir`=1 after SETTLE.
- Throttled 96-tap load:
  - Stimulus: mode=3, `s_valid` toggled every other cycle.
  - Response: addresses 0..95 with no gaps or duplicates; `done` exactly once.
- Timeout:
  - Stimulus: LOAD reached, 10 coefficients sent, then `s_valid` held low.
  - Response: `err_timeout`=1 after 1024 idle cycles; `en_rfir`=0, old mode retained, `busy`=0 two cycles later.
- Abort, then restart:
  - Stimulus: `abort` coincident with the 5th handshake; then a new `cfg_start`.
  - Response: only addresses 0..3 written; `err_abort`=1; the new `cfg_start` clears `err_abort`.
- Reset and dropped start:
  - Stimulus: reset asserted mid-LOAD; separately, `cfg_start` pulsed while `busy`=1.
  - Response: all outputs at reset values asynchronously, without waiting for a clock edge; the `cfg_start` during `busy` leaves the shadow registers unchanged.
